mux_bist_ctrl: RTL and testbench

MUX_BIST_CTRL -- requirements
Module: mux_bist_ctrl

---
 rtl/mux_bist_ctrl.sv | 62 ++++++
 tb/tb_mux_bist_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_bist_ctrl.sv
// mux_bist_ctrl: BIST sequencer that walks all 64 vectors of a 4:1 mux and scores its response
module mux_bist_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [6:0] fail_count,
  output logic [5:0] first_fail_vec,
  output logic       first_fail_valid
);
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] vec;
  logic [3:0] data;
  logic go, miss, last;
  assign {sel, d, c, b, a} = vec;
  assign data = vec[3:0];
  assign miss = mux_out !== data[vec[5:4]];
  assign last = vec == 6'd63;
  assign go = !abort && start && (state == IDLE || state == DONE);
  assign busy = state == APPLY || state == CHECK;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = (abort && state != IDLE) ? IDLE :
               go                       ? APPLY :
               state == APPLY           ? CHECK :
               state == CHECK           ? (last ? DONE : APPLY) : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vec <= '0;
    else if (abort || go) vec <= '0;
    else if (state == CHECK && !last) vec <= vec + 6'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fault <= 1'b0;
      fail_count <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end else if (go) begin
      fault <= 1'b0;
      fail_count <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == CHECK && !abort && miss) begin
      fault <= 1'b1;
      fail_count <= fail_count + 7'd1;
      first_fail_vec <= first_fail_valid ? first_fail_vec : vec;
      first_fail_valid <= 1'b1;
    end
endmodule

// File: tb/tb_mux_bist_ctrl.sv
// tb_mux_bist_ctrl: randomized self-checking bench with a faultable mux model and vector-level reference
module tb_mux_bist_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, abort, mux_out;
  logic a, b, c, d, busy, done, fault, first_fail_valid;
  logic [1:0] sel;
  logic [6:0] fail_count;
  logic [5:0] first_fail_vec;
  logic [5:0] cur;
  logic xv = 1'b1;
  logic probe;
  int total = 0;
  int bad = 0;
  int mode = 0;
  bit flip [64];

  always #5 clk = ~clk;

  mux_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mux_out(mux_out),
    .a(a), .b(b), .c(c), .d(d), .sel(sel), .busy(busy), .done(done), .fault(fault),
    .fail_count(fail_count), .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );

  function automatic int ideal(int v);
    return ((v % 16) >> (v / 16)) & 1;
  endfunction

  function automatic bit miss_of(int m, int v);
    case (m)
      1: return ideal(v) == 1;
      2: return ideal(v) != (((v % 16) >> ((v / 16) & 2)) & 1);
      3: return v == 0;
      4: return flip[v];
      default: return 1'b0;
    endcase
  endfunction

  assign cur = {sel, d, c, b, a};

  always_comb begin
    mux_out = 1'(ideal(int'(cur)));
    if (mode == 1) mux_out = 1'b0;
    else if (mode == 2) mux_out = 1'((int'(cur[3:0]) >> (int'(cur[5:4]) & 2)) & 1);
    else if (mode == 3 && cur == 6'd0) mux_out = xv;
    else if (mode == 4) mux_out = mux_out ^ flip[cur];
  end

  task automatic do_run(input int m, input int abort_at, input int restart_at, input string nm);
    int exp_cnt, exp_first, lim, seq_bad, bad_cyc;
    logic [5:0] s;
    mode = m;
    exp_cnt = 0;
    exp_first = 0;
    lim = abort_at >= 0 ? abort_at : 64;
    for (int v = lim - 1; v >= 0; v--)
      if (miss_of(m, v)) begin
        exp_cnt++;
        exp_first = v;
      end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seq_bad = 0;
    bad_cyc = -1;
    for (int cyc = 0; cyc < 128; cyc++) begin
      s = {sel, d, c, b, a};
      if (busy !== 1'b1 || done !== 1'b0 || s !== 6'(cyc / 2)) begin
        seq_bad++;
        if (bad_cyc < 0) bad_cyc = cyc;
      end
      if (abort_at >= 0 && cyc == 2 * abort_at + 1) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        break;
      end
      start = cyc == 2 * restart_at;
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (seq_bad != 0) begin
      bad++;
      $display("FAIL %s sequence: got %0d bad cycles (first at cycle %0d), required 0", nm, seq_bad, bad_cyc);
    end
    s = {sel, d, c, b, a};
    total++;
    if (abort_at >= 0) begin
      if (busy !== 1'b0 || done !== 1'b0 || s !== 6'd0) begin
        bad++;
        $display("FAIL %s abort_idle: got busy=%b done=%b stim=%0d, required 0 0 0", nm, busy, done, s);
      end
    end else if (busy !== 1'b0 || done !== 1'b1 || s !== 6'd63) begin
      bad++;
      $display("FAIL %s done_entry: got busy=%b done=%b stim=%0d, required 0 1 63", nm, busy, done, s);
    end
    total++;
    if (fail_count !== 7'(exp_cnt)) begin
      bad++;
      $display("FAIL %s fail_count: got %0d, required %0d", nm, fail_count, exp_cnt);
    end
    total++;
    if (fault !== (exp_cnt != 0) || first_fail_valid !== (exp_cnt != 0)) begin
      bad++;
      $display("FAIL %s fault_flags: got fault=%b valid=%b, required %b", nm, fault, first_fail_valid, exp_cnt != 0);
    end
    if (exp_cnt != 0) begin
      total++;
      if (first_fail_vec !== 6'(exp_first)) begin
        bad++;
        $display("FAIL %s first_fail_vec: got %0d, required %0d", nm, first_fail_vec, exp_first);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({sel, d, c, b, a, busy, done} !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got stim=%0d busy=%b done=%b, required all 0", cur, busy, done);
    end
    total++;
    if (fault !== 1'b0 || fail_count !== 7'd0 || first_fail_vec !== 6'd0 || first_fail_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_score: got fault=%b cnt=%0d vec=%0d valid=%b, required all 0", fault, fail_count, first_fail_vec, first_fail_valid);
    end
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || cur !== 6'd0) begin
      bad++;
      $display("FAIL reset_first_edge: got busy=%b stim=%0d, required 1 0", busy, cur);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (74) @(negedge clk);
    total++;
    if (cur !== 6'd37 || fail_count === 7'd0) begin
      bad++;
      $display("FAIL reset_mid_pre: got stim=%0d cnt=%0d, required 37 and nonzero", cur, fail_count);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sel, d, c, b, a, busy, done, fault, first_fail_valid} !== 10'd0 || fail_count !== 7'd0 || first_fail_vec !== 6'd0) begin
      bad++;
      $display("FAIL reset_mid_async: got stim=%0d busy=%b done=%b fault=%b cnt=%0d vec=%0d valid=%b, required all 0",
               cur, busy, done, fault, fail_count, first_fail_vec, first_fail_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || cur !== 6'd0) begin
      bad++;
      $display("FAIL reset_mid_idle: got busy=%b done=%b stim=%0d, required 0 0 0", busy, done, cur);
    end
  endtask

  task automatic test_good();
    do_run(0, -1, -1, "good");
  endtask

  task automatic test_stuck0();
    do_run(1, -1, -1, "stuck0");
  endtask

  task automatic test_back_to_back();
    do_run(0, -1, -1, "back_to_back");
  endtask

  task automatic test_sel_stuck();
    do_run(2, -1, -1, "sel0_stuck");
  endtask

  task automatic test_x_vec0();
    do_run(3, -1, -1, "x_vec0");
  endtask

  task automatic test_abort();
    foreach (flip[i]) flip[i] = $urandom_range(0, 5) == 0;
    flip[3] = 1'b1;
    flip[10] = 1'b1;
    do_run(4, 10, -1, "abort");
    do_run(0, -1, -1, "after_abort");
  endtask

  task automatic test_restart_ignored();
    do_run(0, -1, 5, "restart_ignored");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      foreach (flip[i]) flip[i] = $urandom_range(0, 7) == 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(4, -1, -1, "random");
    end
  endtask

  initial begin
    probe = 1'bx;
    xv = $isunknown(probe) ? 1'bx : 1'b1;
    test_reset();
    test_good();
    test_stuck0();
    test_back_to_back();
    test_sel_stuck();
    test_x_vec0();
    test_abort();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
